// File: rtl/buf_stream_tx_pkg.sv
// Shared definitions for the buffer reader: FSM state encoding and the
// default widths agreed with the block-RAM buffer.
package buf_stream_tx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int BUF_DATA_WIDTH = 24;
  localparam int BUF_ADDR_WIDTH = 18;
  localparam int BUF_DATA_DEPTH = 24;

endpackage

// File: rtl/buf_stream_tx_if.sv
// Buffer read port plus AXI4-Stream master bundled as one interface.
// master = the reader (buf_stream_tx); slave = buffer memory and stream sink.
interface buf_stream_tx_if #(
  parameter int DATA_WIDTH = 24,
  parameter int ADDR_WIDTH = 18
);
  logic                  mem_ce;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_q;

  // A beat transfers on every cycle with m_axis_tvalid && m_axis_tready; once
  // tvalid rises, tvalid/tdata/tlast hold unchanged until that handshake.
  logic [DATA_WIDTH-1:0] m_axis_tdata;
  logic                  m_axis_tvalid;
  logic                  m_axis_tready;
  logic                  m_axis_tlast;

  modport master (
    output mem_ce, mem_we, mem_addr,
    input  mem_q,
    output m_axis_tdata, m_axis_tvalid, m_axis_tlast,
    input  m_axis_tready
  );

  modport slave (
    input  mem_ce, mem_we, mem_addr,
    output mem_q,
    input  m_axis_tdata, m_axis_tvalid, m_axis_tlast,
    output m_axis_tready
  );
endinterface

// File: rtl/buf_stream_tx.sv
// Drains eff_len = min(len, DATA_DEPTH) words from buffer address 0 onto an
// AXI4-Stream master. Define BUF_STREAM_TX_TLAST_EN to drive m_axis_tlast.
module buf_stream_tx
  import buf_stream_tx_pkg::*;
#(
  parameter int DATA_WIDTH = BUF_DATA_WIDTH,
  parameter int DATA_DEPTH = BUF_DATA_DEPTH,
  parameter int ADDR_WIDTH = BUF_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] len,
  output logic                  busy,
  output logic                  done,
  output state_t                state,
  buf_stream_tx_if.master       bus
);

  localparam logic [ADDR_WIDTH-1:0] DEPTH_LIM = ADDR_WIDTH'(DATA_DEPTH);

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] eff_len_q;
  logic [ADDR_WIDTH-1:0] rd_ptr_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  valid_q;
  logic                  last_q;
  logic                  fetch;
  logic                  handshake;

  // A new word is read only when the output register is empty or draining.
  assign fetch     = (state_q == ST_RUN) && (rd_ptr_q < eff_len_q) &&
                     (!valid_q || bus.m_axis_tready);
  assign handshake = valid_q && bus.m_axis_tready;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start) state_d = ST_RUN;
      ST_RUN: begin
        if (eff_len_q == '0)        state_d = ST_DONE;
        else if (handshake && last_q) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      eff_len_q <= '0;
      rd_ptr_q  <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      last_q    <= 1'b0;
    end else begin
      if (state_q == ST_IDLE && start) begin
        eff_len_q <= (len > DEPTH_LIM) ? DEPTH_LIM : len;
        rd_ptr_q  <= '0;
      end
      if (fetch) begin
        data_q   <= bus.mem_q;
        valid_q  <= 1'b1;
        rd_ptr_q <= rd_ptr_q + ADDR_WIDTH'(1);
        last_q   <= (rd_ptr_q == eff_len_q - ADDR_WIDTH'(1));
      end else if (handshake) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign bus.mem_ce        = fetch;
  assign bus.mem_we        = 1'b0;
  assign bus.mem_addr      = fetch ? rd_ptr_q : '0;
  assign bus.m_axis_tdata  = data_q;
  assign bus.m_axis_tvalid = valid_q;
`ifdef BUF_STREAM_TX_TLAST_EN
  assign bus.m_axis_tlast  = last_q;
`else
  assign bus.m_axis_tlast  = 1'b0;
`endif

  assign busy  = (state_q != ST_IDLE);
  assign done  = (state_q == ST_DONE);
  assign state = state_q;

endmodule

// File: doc/buf_stream_tx.md
# buf_stream_tx

Reader side of the accelerator's on-chip block-RAM buffer. On a start pulse it walks `len` consecutive words starting at address 0 through the buffer's single-port memory interface (ce/addr/we/q, combinational read data) and emits them as an AXI4-Stream master toward the DMA S2MM channel. It is the drain counterpart of the logic that fills the buffer.

## Interface
- `DATA_WIDTH`, 24: word width; matches the buffer and `m_axis_tdata`.
- `DATA_DEPTH`, 24: buffer depth in words; upper bound on transfer length.
- `ADDR_WIDTH`, 18: buffer address width.
- `clk` in 1: single clock; all logic is on its rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: one-cycle request; sampled only in IDLE.
- `len` in ADDR_WIDTH: number of words to send; sampled together with `start`.
- `busy` out 1: high from the cycle after an accepted start through the DONE cycle.
- `done` out 1: one-cycle pulse at the end of a transfer.
- `mem_ce` out 1: buffer chip enable.
- `mem_we` out 1: constant 0 (read only).
- `mem_addr` out ADDR_WIDTH: buffer read address.
- `mem_q` in DATA_WIDTH: buffer read data, valid combinationally in the same cycle as ce/addr.
- `m_axis_tdata` out DATA_WIDTH, `m_axis_tvalid` out 1, `m_axis_tready` in 1, `m_axis_tlast` out 1: AXI4-Stream master.

## Operation
- States: IDLE, RUN, DONE.
  - IDLE -> RUN on `start`. Latch `eff_len = min(len, DATA_DEPTH)` and clear `rd_ptr` and `sent`.
  - RUN -> DONE on the handshake of beat number `eff_len` (the `m_axis_tvalid && m_axis_tready` cycle).
  - RUN -> DONE on the cycle after entry if `eff_len == 0`. No beats are sent in that case.
  - DONE -> IDLE unconditionally after one cycle.
- `start` is ignored outside IDLE.
- Fetch condition, evaluated combinationally: `fetch = RUN && rd_ptr < eff_len && (!m_axis_tvalid || m_axis_tready)`.
  - `mem_ce = fetch`.
  - `mem_addr = rd_ptr` when `fetch` is high, otherwise 0.
- On fetch:
  - `m_axis_tdata <= mem_q`.
  - `m_axis_tvalid <= 1`.
  - `rd_ptr <= rd_ptr + 1`.
  - Internal `last_q <= (rd_ptr == eff_len-1)`.
- On a handshake without a fetch, `m_axis_tvalid <= 0`.
- `m_axis_tdata` and `m_axis_tlast` hold stable while `m_axis_tvalid && !m_axis_tready`.
- `rd_ptr` counts 0..eff_len and never wraps. Comparisons are unsigned at ADDR_WIDTH.
- `done` is high exactly in DONE. `busy` is high in RUN and DONE.
- Reset, including mid-transfer: state returns to IDLE and every output goes to 0. The transfer is abandoned and no `done` is issued.

## Timing
- Cycle 0: `start` sampled in IDLE.
- Cycle 1: RUN; `mem_ce` = 1 with `mem_addr` = 0.
- Cycle 2: first beat valid on `m_axis_tdata`.
- With `m_axis_tready` held high, the block sends one beat per cycle with no bubbles.
- `done` asserts the cycle after the last handshake. `busy` falls one cycle after that.
- Minimum start-to-start spacing, including the `len == 0` case, is `eff_len + 3` cycles.

## Configuration
- `BUF_STREAM_TX_TLAST_EN` defined: `m_axis_tlast` = `last_q`, which is high on the final beat only.
- Not defined: `m_axis_tlast` is tied 0. All other behaviour, including DONE detection through the internal `last_q`, is unchanged.

## Structure
- Shared package `buf_stream_tx_pkg` contains:
  - The state encoding typedef (IDLE, RUN, DONE).
  - Default width constants (DATA_WIDTH 24, ADDR_WIDTH 18) shared with the buffer.
- There is no sub-module. The one-entry output register is inline; splitting it out is not warranted at this size.

## Test plan
- Buffer preloaded with word i at address i. Pulse `start` with len = 4 and tready held 1 -> beats 0,1,2,3 in cycles 2-5. tlast is high only on 3 (macro defined). `done` pulses in cycle 6.
- len = 6 with tready toggling 1,0,1,0 -> six beats with data 0..5 in order. tdata is stable while stalled. `mem_ce` is never high while tvalid=1 and tready=0.
- len = 0 -> no tvalid at any point. `done` in cycle 2. `busy` high in cycles 1-2.
- len = 100 with DATA_DEPTH = 24 -> exactly 24 beats, max `mem_addr` = 23, then `done`.
- `start` re-pulsed during RUN of a len = 8 transfer -> ignored; exactly 8 beats and one `done`.
- `rst` asserted after 3 beats of a len = 10 transfer -> all outputs 0 in the same cycle and no `done`. A following len = 2 start sends words 0,1.
